// File: rtl/mac128_palcl_if.sv
`timescale 1ns/1ps
// mac128_palcl_if: 68000 address/strobe bus plus the DRAM control bundle
// exchanged between the CPU side and the Mac 128K glue logic.
//   master : CPU side, drives address and bus strobes, sees selects/ack/DRAM strobes
//   slave  : glue logic, decodes the bus and drives selects, n_dtack and DRAM strobes
// Active-low throughout except the address (a) and row/column address (ra).
interface mac128_palcl_if;
  logic [23:1] a;
  logic        n_as, n_uds, n_lds, r_n_w;
  logic        n_dtack;
  logic        n_ramen, n_romen, n_csiwm, n_sccrd, n_cescc, n_vpa;
  logic        ras, cash, casl, we;
  logic [9:0]  ra;

  modport master (
    output a, n_as, n_uds, n_lds, r_n_w,
    input  n_dtack, n_ramen, n_romen, n_csiwm, n_sccrd, n_cescc, n_vpa,
    input  ras, cash, casl, we, ra
  );

  modport slave (
    input  a, n_as, n_uds, n_lds, r_n_w,
    output n_dtack, n_ramen, n_romen, n_csiwm, n_sccrd, n_cescc, n_vpa,
    output ras, cash, casl, we, ra
  );
endinterface

// File: rtl/mac128_palcl.sv
`timescale 1ns/1ps
// mac128_palcl: Mac 128K glue logic (PAL set) as one simclk-synchronous block.
//   - derives sysclk/pclk/p0q1/clkscc/p0q2/vclk/q3/q4 from the sampled crystal 'clock'
//   - decodes the 68000 address into RAM/ROM/SCC/IWM/VIA selects, generates n_dtack
//     and the DRAM strobes (ras/cash/casl/we, active-low) with row/column mux on ra
//   - steers data between CPU bus d and DRAM bus rdq (registered, tri-stated)
//   - n_ipl0 = n_intscc & n_intvia, viacb1 = keyclk (both registered)
//   - video sync/pixel output
// Ports: simclk/n_res (clock, sync active-low reset); bus = mac128_palcl_if.slave;
//   d/rdq inout 16-bit buses; remaining scalars as named in the port list.
// Build option: PALCL_VIDEO_EN defined -> pixel/line counters, viapb6, n_hsync,
//   n_vsync and vid shifter. Undefined -> n_hsync=n_vsync=1, vid=0, viapb6=0.
// vcc, gnd, e, n_sndpg2, n_vidpg2 are accepted but have no function here.
module mac128_palcl #(
  parameter int H_TOTAL = 704,
  parameter int V_TOTAL = 370
) (
  input  logic          simclk,
  input  logic          n_res,
  input  logic          vcc,
  input  logic          gnd,
  input  logic          clock,
  output logic          sysclk,
  output logic          pclk,
  output logic          p0q1,
  output logic          clkscc,
  output logic          p0q2,
  output logic          vclk,
  output logic          q3,
  output logic          q4,
  input  logic          e,
  input  logic          keyclk,
  mac128_palcl_if.slave bus,
  inout  wire  [15:0]   d,
  inout  wire  [15:0]   rdq,
  input  logic          n_intscc,
  input  logic          n_intvia,
  output logic          n_ipl0,
  output logic          viapb6,
  input  logic          ovlay,
  output logic          viacb1,
  input  logic          n_sndpg2,
  input  logic          n_vidpg2,
  output logic          n_vsync,
  output logic          n_hsync,
  output logic          vid
);

  logic        clock_q, clock_d;
  logic        clk_rise;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  dclk_q, dclk_d;   // {q4,q3,p0q2,clkscc,p0q1,pclk,sysclk}
  logic [1:0]  as_cnt_q, as_cnt_d; // clk_rise count since n_as fell, saturating
  logic [5:0]  sel_q, sel_d;     // {n_ramen,n_romen,n_csiwm,n_sccrd,n_cescc,n_vpa}
  logic        n_dtack_q, n_dtack_d;
  logic        ras_q, ras_d, cash_q, cash_d, casl_q, casl_d, we_q, we_d;
  logic [9:0]  ra_q, ra_d;
  logic        d_oe_q, d_oe_d, rdq_oe_q, rdq_oe_d;
  logic [15:0] d_out_q, d_out_d, rdq_out_q, rdq_out_d;
  logic        n_ipl0_q, n_ipl0_d, viacb1_q, viacb1_d;
  logic [2:0]  region;
  logic        as_act, ram_hit, rom_hit, scc_hit, iwm_hit, vpa_hit;

  // The crystal edge detector keeps tracking through reset so that releasing
  // reset while 'clock' is high does not fake a rising edge.
  always_ff @(posedge simclk) clock_q <= clock_d;

  always_comb begin
    clock_d  = clock;
    clk_rise = clock & ~clock_q;
    cnt_d    = cnt_q + {2'b00, clk_rise};
    dclk_d   = {cnt_d[2] & cnt_d[1], cnt_d[1] & cnt_d[0], cnt_d[2],
                cnt_d[1], cnt_d[1], ~cnt_d[0], cnt_d[0]};

    region  = bus.a[23:21];
    as_act  = ~bus.n_as;
    ram_hit = as_act & (region[2:1] == 2'b00) & ~ovlay;
    rom_hit = as_act & (((region[2:1] == 2'b00) & ovlay) | (region[2:1] == 2'b01));
    scc_hit = as_act & (region[2:1] == 2'b10);
    iwm_hit = as_act & (region == 3'b110);
    vpa_hit = as_act & (region == 3'b111);
    sel_d   = ~{ram_hit, rom_hit, iwm_hit, scc_hit & bus.r_n_w, scc_hit, vpa_hit};

    as_cnt_d = as_cnt_q;
    if (!as_act)                            as_cnt_d = 2'd0;
    else if (clk_rise && as_cnt_q != 2'd3)  as_cnt_d = as_cnt_q + 2'd1;

    // VIA space (111) is an autovector/VPA cycle: no DTACK ever.
    n_dtack_d = ~(as_act & ~vpa_hit & (as_cnt_d >= 2'd2));
    ras_d     = ~(ram_hit & (as_cnt_d >= 2'd1));
    cash_d    = ~(ram_hit & (as_cnt_d >= 2'd2) & ~bus.n_uds);
    casl_d    = ~(ram_hit & (as_cnt_d >= 2'd2) & ~bus.n_lds);
    we_d      = ~ram_hit | bus.r_n_w;
    // Row address while RAS is high, column address once it has fallen.
    ra_d      = ras_d ? bus.a[10:1] : bus.a[20:11];

    d_oe_d    = ram_hit & bus.r_n_w;
    rdq_oe_d  = ram_hit & ~bus.r_n_w;
    d_out_d   = rdq;
    rdq_out_d = d;

    n_ipl0_d  = n_intscc & n_intvia;
    viacb1_d  = keyclk;
  end

  always_ff @(posedge simclk) begin
    if (!n_res) begin
      cnt_q     <= 3'd0;
      dclk_q    <= 7'b0000010;
      as_cnt_q  <= 2'd0;
      sel_q     <= 6'h3f;
      n_dtack_q <= 1'b1;
      ras_q     <= 1'b1;
      cash_q    <= 1'b1;
      casl_q    <= 1'b1;
      we_q      <= 1'b1;
      ra_q      <= 10'd0;
      d_oe_q    <= 1'b0;
      rdq_oe_q  <= 1'b0;
      d_out_q   <= 16'd0;
      rdq_out_q <= 16'd0;
      n_ipl0_q  <= 1'b1;
      viacb1_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dclk_q    <= dclk_d;
      as_cnt_q  <= as_cnt_d;
      sel_q     <= sel_d;
      n_dtack_q <= n_dtack_d;
      ras_q     <= ras_d;
      cash_q    <= cash_d;
      casl_q    <= casl_d;
      we_q      <= we_d;
      ra_q      <= ra_d;
      d_oe_q    <= d_oe_d;
      rdq_oe_q  <= rdq_oe_d;
      d_out_q   <= d_out_d;
      rdq_out_q <= rdq_out_d;
      n_ipl0_q  <= n_ipl0_d;
      viacb1_q  <= viacb1_d;
    end
  end

  assign {q4, q3, p0q2, clkscc, p0q1, pclk, sysclk} = dclk_q;
  assign vclk = clock_q;

  assign {bus.n_ramen, bus.n_romen, bus.n_csiwm, bus.n_sccrd, bus.n_cescc, bus.n_vpa} = sel_q;
  assign bus.n_dtack = n_dtack_q;
  assign bus.ras     = ras_q;
  assign bus.cash    = cash_q;
  assign bus.casl    = casl_q;
  assign bus.we      = we_q;
  assign bus.ra      = ra_q;

  assign d   = d_oe_q   ? d_out_q   : 16'bz;
  assign rdq = rdq_oe_q ? rdq_out_q : 16'bz;

  assign n_ipl0 = n_ipl0_q;
  assign viacb1 = viacb1_q;

`ifdef PALCL_VIDEO_EN
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);

  logic [9:0]  pix_q, pix_d;
  logic [8:0]  line_q, line_d;
  logic [15:0] shreg_q, shreg_d;
  logic        viapb6_q, viapb6_d, n_hsync_q, n_hsync_d, n_vsync_q, n_vsync_d;
  logic        vid_q, vid_d;
  logic        vis;

  always_comb begin
    pix_d  = pix_q;
    line_d = line_q;
    if (clk_rise) begin
      if (pix_q == H_LAST) begin
        pix_d  = 10'd0;
        line_d = (line_q == V_LAST) ? 9'd0 : line_q + 9'd1;
      end else begin
        pix_d  = pix_q + 10'd1;
      end
    end
    vis = (pix_d < 10'd512) && (line_d < 9'd342);
    // Fetch a fresh word from the DRAM bus at each 16-pixel boundary.
    shreg_d = shreg_q;
    if (clk_rise)
      shreg_d = (vis && pix_d[3:0] == 4'd0) ? rdq : {shreg_q[14:0], 1'b0};
    vid_d     = vis & shreg_d[15];
    viapb6_d  = pix_d >= 10'd512;
    n_hsync_d = ~((pix_d >= 10'd528) && (pix_d <= 10'd623));
    n_vsync_d = ~((line_d >= 9'd342) && (line_d <= 9'd345));
  end

  always_ff @(posedge simclk) begin
    if (!n_res) begin
      pix_q     <= 10'd0;
      line_q    <= 9'd0;
      shreg_q   <= 16'd0;
      viapb6_q  <= 1'b0;
      n_hsync_q <= 1'b1;
      n_vsync_q <= 1'b1;
      vid_q     <= 1'b0;
    end else begin
      pix_q     <= pix_d;
      line_q    <= line_d;
      shreg_q   <= shreg_d;
      viapb6_q  <= viapb6_d;
      n_hsync_q <= n_hsync_d;
      n_vsync_q <= n_vsync_d;
      vid_q     <= vid_d;
    end
  end

  assign viapb6  = viapb6_q;
  assign n_hsync = n_hsync_q;
  assign n_vsync = n_vsync_q;
  assign vid     = vid_q;
`else
  assign viapb6  = 1'b0;
  assign n_hsync = 1'b1;
  assign n_vsync = 1'b1;
  assign vid     = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{vcc, gnd, e, n_sndpg2, n_vidpg2,
                       1'(H_TOTAL == 0), 1'(V_TOTAL == 0)};

endmodule

// File: tb/tb_mac128_palcl.sv
`timescale 1ns/1ps
module tb_mac128_palcl;
  logic simclk, clock, n_res, vcc, gnd, e, keyclk, n_intscc, n_intvia, ovlay;
  logic n_sndpg2, n_vidpg2;
  logic sysclk, pclk, p0q1, clkscc, p0q2, vclk, q3, q4;
  logic n_ipl0, viapb6, viacb1, n_vsync, n_hsync, vid;
  wire  [15:0] d, rdq;
  logic [15:0] tb_d, tb_rdq, vpat;
  logic        tb_d_en, tb_rdq_en;
  int total = 0;
  int bad   = 0;
  int rises = 0;
  int hs_low = 0;

  mac128_palcl_if bus();

  assign d   = tb_d_en   ? tb_d   : 16'bz;
  assign rdq = tb_rdq_en ? tb_rdq : 16'bz;

  mac128_palcl dut (
    .simclk(simclk), .n_res(n_res), .vcc(vcc), .gnd(gnd), .clock(clock),
    .sysclk(sysclk), .pclk(pclk), .p0q1(p0q1), .clkscc(clkscc), .p0q2(p0q2),
    .vclk(vclk), .q3(q3), .q4(q4), .e(e), .keyclk(keyclk), .bus(bus),
    .d(d), .rdq(rdq), .n_intscc(n_intscc), .n_intvia(n_intvia), .n_ipl0(n_ipl0),
    .viapb6(viapb6), .ovlay(ovlay), .viacb1(viacb1), .n_sndpg2(n_sndpg2),
    .n_vidpg2(n_vidpg2), .n_vsync(n_vsync), .n_hsync(n_hsync), .vid(vid)
  );

  initial begin simclk = 1'b0; forever #1  simclk = ~simclk; end
  initial begin clock  = 1'b0; forever #32 clock  = ~clock;  end

  // Reference: number of crystal rising edges since reset was released.
  always @(posedge clock or negedge n_res)
    if (!n_res) rises <= 0;
    else        rises <= rises + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sim_step();
    @(posedge simclk); @(negedge simclk);
  endtask

  // Returns at the first sampling point after the next crystal rising edge.
  task automatic step_rise();
    @(posedge clock); @(posedge simclk); @(negedge simclk);
  endtask

  // {sysclk,pclk,p0q1,clkscc,p0q2,q3,q4} for a 3-bit count of r crystal edges.
  function automatic logic [6:0] clk_exp(input int r);
    int c;
    c = r % 8;
    return {c % 2 == 1, c % 2 == 0, (c / 2) % 2 == 1, (c / 2) % 2 == 1,
            c >= 4, c % 4 == 3, c >= 6};
  endfunction

  // {n_ramen,n_romen,n_csiwm,n_sccrd,n_cescc,n_vpa} for a 2 MB region number.
  function automatic logic [5:0] sel_exp(input int rg, input logic rnw, input logic ovl);
    logic ram, rom, scc;
    ram = (rg < 2) && !ovl;
    rom = ((rg < 2) && ovl) || rg == 2 || rg == 3;
    scc = rg == 4 || rg == 5;
    return ~{ram, rom, rg == 6, scc && rnw, scc, rg == 7};
  endfunction

  function automatic logic [31:0] sel_obs();
    return 32'({bus.n_ramen, bus.n_romen, bus.n_csiwm, bus.n_sccrd, bus.n_cescc, bus.n_vpa});
  endfunction

  task automatic bus_cycle(input logic [23:0] addr, input logic rnw, input logic ovl,
                           input logic uds, input logic lds);
    int rg;
    logic ram;
    logic [15:0] dat;
    rg  = int'(addr[23:21]);
    ram = (rg < 2) && !ovl;
    dat = 16'($urandom);
    step_rise();
    bus.a = addr[23:1]; bus.r_n_w = rnw; bus.n_uds = uds; bus.n_lds = lds; ovlay = ovl;
    if (rnw) begin tb_d_en = 1'b0; tb_rdq = dat; tb_rdq_en = 1'b1; end
    else     begin tb_d = dat; tb_d_en = 1'b1; tb_rdq_en = !ram; end
    bus.n_as = 1'b0;
    sim_step();
    chk("sel", sel_obs(), 32'(sel_exp(rg, rnw, ovl)));
    chk("ra_row", 32'(bus.ra), 32'(addr[10:1]));
    chk("early_strobes", 32'({bus.n_dtack, bus.ras, bus.cash, bus.casl}), 32'hF);
    chk("we", 32'(bus.we), 32'(!ram || rnw));
    step_rise();
    chk("ras_1st", 32'(bus.ras), 32'(!ram));
    chk("ra_col", 32'(bus.ra), ram ? 32'(addr[20:11]) : 32'(addr[10:1]));
    chk("dtack_1st", 32'(bus.n_dtack), 32'd1);
    step_rise();
    chk("dtack_2nd", 32'(bus.n_dtack), 32'(rg == 7));
    chk("cas", 32'({bus.cash, bus.casl}), 32'({!(ram && !uds), !(ram && !lds)}));
    if (ram) begin
      if (rnw) chk("d_from_rdq", 32'(d), 32'(dat));
      else     chk("rdq_from_d", 32'(rdq), 32'(dat));
    end
    bus.n_as = 1'b1;
    sim_step();
    chk("idle_strobes", 32'({bus.n_dtack, bus.ras, bus.cash, bus.casl, bus.we}), 32'h1F);
    chk("idle_sel", sel_obs(), 32'h3F);
    tb_d = ~dat; tb_d_en = 1'b1; tb_rdq = dat; tb_rdq_en = 1'b1;
    sim_step();
    chk("bus_release", 32'({d, rdq}), 32'({~dat, dat}));
  endtask

  initial begin
    int p, l;
    n_res = 1'b0; vcc = 1'b1; gnd = 1'b0; e = 1'b0; keyclk = 1'b0;
    n_intscc = 1'b1; n_intvia = 1'b1; ovlay = 1'b1; n_sndpg2 = 1'b1; n_vidpg2 = 1'b1;
    bus.a = '0; bus.n_as = 1'b1; bus.n_uds = 1'b1; bus.n_lds = 1'b1; bus.r_n_w = 1'b1;
    tb_d = 16'hA5A5; tb_rdq = 16'h5A5A; tb_d_en = 1'b1; tb_rdq_en = 1'b1;
    vpat = 16'hC3A5;

    // Reset state.
    #16;
    chk("rst_strobes", 32'({bus.n_dtack, bus.ras, bus.cash, bus.casl, bus.we}), 32'h1F);
    chk("rst_sel", sel_obs(), 32'h3F);
    chk("rst_clks", 32'({sysclk, pclk, p0q1, clkscc, p0q2, q3, q4}), 32'(clk_exp(0)));
    chk("rst_ipl", 32'(n_ipl0), 32'd1);
    chk("rst_bus_z", 32'({d, rdq}), 32'hA5A55A5A);
    chk("rst_video", 32'({n_hsync, n_vsync, vid, viapb6}), 32'b1100);
    #2 n_res = 1'b1;

    // Derived clocks through a full count wrap.
    for (int i = 0; i < 9; i++) begin
      step_rise();
      chk("clks", 32'({sysclk, pclk, p0q1, clkscc, p0q2, q3, q4}), 32'(clk_exp(rises)));
      chk("vclk", 32'(vclk), 32'd1);
    end

    // Interrupt merge and keyboard clock.
    for (int i = 0; i < 6; i++) begin
      logic [1:0] irq;
      irq = (i < 4) ? 2'(i) : 2'($urandom);
      n_intscc = irq[1]; n_intvia = irq[0]; keyclk = 1'($urandom);
      sim_step();
      chk("ipl0", 32'(n_ipl0), 32'(irq[1] & irq[0]));
      chk("viacb1", 32'(viacb1), 32'(keyclk));
    end

    // Directed decode corners, then random bus cycles.
    bus_cycle(24'h000000, 1'b1, 1'b1, 1'b0, 1'b0);
    bus_cycle(24'h000000, 1'b1, 1'b0, 1'b0, 1'b0);
    bus_cycle(24'h1FFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    bus_cycle(24'h9FFFFE, 1'b1, 1'b0, 1'b0, 1'b0);
    bus_cycle(24'h9FFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    bus_cycle(24'hEFE1FE, 1'b1, 1'b0, 1'b0, 1'b0);
    bus_cycle(24'hDFE1FE, 1'b1, 1'b0, 1'b1, 1'b0);
    bus_cycle(24'h400000, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      bus_cycle(24'($urandom) & 24'hFFFFFE, 1'($urandom), 1'($urandom_range(0, 3) == 0),
                1'($urandom), 1'($urandom));

    // Reset in the middle of a RAM read.
    step_rise();
    bus.a = 23'h00091A; bus.r_n_w = 1'b1; ovlay = 1'b0; bus.n_uds = 1'b0; bus.n_lds = 1'b0;
    tb_d_en = 1'b0; tb_rdq = 16'h1234; tb_rdq_en = 1'b1;
    bus.n_as = 1'b0;
    step_rise();
    chk("mid_ras", 32'(bus.ras), 32'd0);
    n_res = 1'b0;
    sim_step(); sim_step();
    chk("mid_strobes", 32'({bus.n_dtack, bus.ras, bus.cash, bus.casl, bus.we}), 32'h1F);
    chk("mid_sel", sel_obs(), 32'h3F);
    chk("mid_clks", 32'({sysclk, pclk, p0q1, clkscc, p0q2, q3, q4}), 32'(clk_exp(0)));
    tb_d = 16'h0F0F; tb_d_en = 1'b1;
    sim_step();
    chk("mid_release", 32'({d, rdq}), 32'h0F0F1234);
    bus.n_as = 1'b1;
    n_res = 1'b1;
    step_rise();
    chk("post_rst_clks", 32'({sysclk, pclk, p0q1, clkscc, p0q2, q3, q4}), 32'(clk_exp(rises)));

    // Video: restart the counters with a fixed DRAM word on rdq.
    step_rise();
    tb_rdq = vpat; tb_rdq_en = 1'b1;
    n_res = 1'b0;
    sim_step(); sim_step();
    n_res = 1'b1;
`ifdef PALCL_VIDEO_EN
    for (int n = 0; n < 800; n++) begin
      step_rise();
      p = rises % 704;
      l = (rises / 704) % 370;
      if (!n_hsync) hs_low++;
      chk("hsync", 32'(n_hsync), 32'(!(p >= 528 && p <= 623)));
      chk("viapb6", 32'(viapb6), 32'(p >= 512));
      chk("vsync", 32'(n_vsync), 32'(!(l >= 342 && l <= 345)));
      if (rises >= 16)
        chk("vid", 32'(vid), (p < 512 && l < 342) ? 32'(vpat[15 - (p % 16)]) : 32'd0);
    end
    chk("hsync_width", 32'(hs_low), 32'd96);
`else
    for (int n = 0; n < 20; n++) begin
      step_rise();
      p = rises % 704;
      l = (rises / 704) % 370;
      chk("novideo", 32'({n_hsync, n_vsync, vid, viapb6}), 32'b1100);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
